// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - UART receive FIFO and RAM write port bundle for the boot loader
interface uart_loader_if;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        busy;
  logic        cpu_run;
  logic        done;
  logic        error;

  modport master (
    input  rx_empty, r_data,
    output rd_uart, addr, wdata, we, busy, cpu_run, done, error
  );

  modport slave (
    output rx_empty, r_data,
    input  rd_uart, addr, wdata, we, busy, cpu_run, done, error
  );
endinterface

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - boot loader: framed UART image into RAM words, then CPU release
// Trailing checksum byte is added when LOADER_CHECKSUM_EN is defined.
module uart_loader #(
  parameter int         NUM_WORDS = 2048,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic           clk,
  input logic           reset,
  uart_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif
  localparam logic [16:0] MAX_LEN = 17'(NUM_WORDS);

  state_t      state, state_next;
  logic        gap;
  logic        consume;
  logic        take;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] widx;
  logic [1:0]  idx;
  logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign len_in = {bus.r_data, len[7:0]};

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    case (state)
      S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA: consume = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: consume = 1'b1;
`endif
      default: consume = 1'b0;
    endcase
    // the cycle after a pop is skipped so the FIFO's empty flag can settle
    take = consume && reset && !gap && !bus.rx_empty;
    case (state)
      S_SYNC:   if (take && bus.r_data == SYNC_BYTE) state_next = S_LEN_LO;
      S_LEN_LO: if (take) state_next = S_LEN_HI;
      S_LEN_HI: if (take) begin
        if ({1'b0, len_in} > MAX_LEN) state_next = S_ERROR;
        else if (len_in == 16'd0)     state_next = S_TAIL;
        else                          state_next = S_DATA;
      end
      S_DATA:   if (take && idx == 2'd3) state_next = S_WRITE;
      S_WRITE:  state_next = (widx + 16'd1 == len) ? S_TAIL : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:   if (take) state_next = (bus.r_data == sum) ? S_DONE : S_ERROR;
`endif
      default:  state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_SYNC;
      gap   <= 1'b0;
      len   <= 16'd0;
      widx  <= 16'd0;
      idx   <= 2'd0;
      word  <= 32'd0;
    end else begin
      state <= state_next;
      gap   <= take;
      if (take) begin
        case (state)
          S_LEN_LO: len[7:0] <= bus.r_data;
          S_LEN_HI: begin
            len[15:8] <= bus.r_data;
            widx      <= 16'd0;
            idx       <= 2'd0;
          end
          S_DATA: begin
            word[{idx, 3'b000} +: 8] <= bus.r_data;
            idx                      <= idx + 2'd1;
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) widx <= widx + 16'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // covers length and payload; any byte taken while hunting for sync restarts it
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= 8'h00;
    end else if (take) begin
      case (state)
        S_SYNC:                     sum <= 8'h00;
        S_LEN_LO, S_LEN_HI, S_DATA: sum <= sum + bus.r_data;
        default: ;
      endcase
    end
  end
`endif

  assign bus.rd_uart = take;
  assign bus.we      = (state == S_WRITE) ? 4'hF : 4'h0;
  assign bus.addr    = {14'd0, widx};
  assign bus.wdata   = word;
  assign bus.busy    = (state != S_DONE) && (state != S_ERROR);
  assign bus.cpu_run = (state == S_DONE);
  assign bus.done    = (state == S_DONE);
  assign bus.error   = (state == S_ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader against a frame-level model
module tb_uart_loader;
  localparam int         NUM_WORDS = 2048;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_loader_if bus ();

  uart_loader #(.NUM_WORDS(NUM_WORDS), .SYNC_BYTE(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  stim[$];
  logic [29:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          pop_times[$];
  logic        exp_done;
  logic        exp_err;
  logic [7:0]  model_sum;
  logic        will_pop = 1'b0;
  logic        prev_rd  = 1'b0;
  logic        checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: list of RAM writes plus final outcome from the byte stream.
  task automatic build_model();
    int i;
    int n;
    logic ok;
    exp_addr.delete();
    exp_data.delete();
    i = 0;
    while (i < stim.size() && stim[i] != SYNC) i++;
    i++;
    n = {16'h0, stim[i+1], stim[i]};
    model_sum = stim[i] + stim[i+1];
    i += 2;
    if (n > NUM_WORDS) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(30'(k));
      exp_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
      model_sum = model_sum + stim[i] + stim[i+1] + stim[i+2] + stim[i+3];
      i += 4;
    end
    ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    ok = (stim[i] == model_sum);
`endif
    exp_done = ok;
    exp_err  = !ok;
  endtask

  task automatic set_frame1();
    stim = '{8'h00, 8'h13, 8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h4E);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    fifo.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int base;
    int n;
    int waited;
    build_model();
    base = pop_times.size();
    foreach (stim[k]) fifo.push_back(stim[k]);
    waited = 0;
    while (!(bus.done || bus.error) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_finished_in_time"}, 32'(waited < budget), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done"}, bus.done, exp_done);
    check({tag, "_error"}, bus.error, exp_err);
    check({tag, "_cpu_run"}, bus.cpu_run, exp_done);
    check({tag, "_writes_missing"}, exp_addr.size(), 0);
    n = pop_times.size() - base;
    if (n > 1) check({tag, "_pop_spacing"}, pop_times[base+n-1] - pop_times[base], 2 * (n - 1));
  endtask

  // UART receive FIFO: pops the head one step after the DUT strobes rd_uart
  always @(posedge clk) begin
    cyc++;
    #1;
    if (will_pop && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pop_times.push_back(cyc);
    end
    bus.rx_empty = (fifo.size() == 0);
    bus.r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy_vs_terminal", bus.busy, !(bus.done || bus.error));
      check("cpu_run_vs_done", bus.cpu_run, bus.done);
      if (bus.cpu_run) check("we_while_cpu_run", bus.we, 4'h0);
      if (bus.rd_uart) begin
        check("rd_while_empty", bus.rx_empty, 1'b0);
        check("rd_back_to_back", prev_rd, 1'b0);
        check("rd_while_idle", bus.busy, 1'b1);
        check("rd_during_write", bus.we, 4'h0);
      end
      if (bus.we != 4'h0) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write", bus.we, 4'h0);
        end else begin
          check("we_value", bus.we, 4'hF);
          check("write_addr", bus.addr, exp_addr.pop_front());
          check("write_data", bus.wdata, exp_data.pop_front());
        end
      end
    end
    prev_rd  = bus.rd_uart;
    will_pop = bus.rd_uart;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    checking = 1'b1;
    check("reset_busy", bus.busy, 1'b1);
    check("reset_we", bus.we, 4'h0);
    check("reset_addr", bus.addr, 30'h0);
    check("reset_wdata", bus.wdata, 32'h0);
    check("reset_cpu_run", bus.cpu_run, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_error", bus.error, 1'b0);
    check("reset_rd_uart", bus.rd_uart, 1'b0);

    set_frame1();
    build_model();
    check("model_words", exp_addr.size(), 2);
    check("model_word0", exp_data[0], 32'h12345678);
    check("model_word1", exp_data[1], 32'hDEADBEEF);
    check("model_addr1", exp_addr[1], 30'd1);
    check("model_sum", model_sum, 8'h4E);
    run_frame("frame1", 200);

    apply_reset();
    stim = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run_frame("empty_image", 200);

    apply_reset();
    stim = '{8'hA5, 8'h01, 8'h08};
    run_frame("oversize", 200);
    check("oversize_error_literal", bus.error, 1'b1);
    check("oversize_cpu_run_literal", bus.cpu_run, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    set_frame1();
    stim[stim.size()-1] = 8'h97;
    run_frame("bad_checksum", 200);
    check("bad_checksum_error_literal", bus.error, 1'b1);
`endif

    apply_reset();
    stim = '{8'hA5, 8'h00, 8'h08};
    for (int k = 0; k < 4 * NUM_WORDS; k++) stim.push_back(8'(k * 7 + 3));
`ifdef LOADER_CHECKSUM_EN
    build_model();
    stim.push_back(model_sum);
`endif
    run_frame("full_ram", 20000);

    // reset after 2 junk + 3 header + 6 payload bytes: only word 0 may land
    apply_reset();
    set_frame1();
    build_model();
    while (exp_addr.size() > 1) begin
      void'(exp_addr.pop_back());
      void'(exp_data.pop_back());
    end
    base = pop_times.size();
    foreach (stim[k]) fifo.push_back(stim[k]);
    w = 0;
    while (pop_times.size() - base < 11 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("partial_reached_cut", 32'(w < 200), 32'd1);
    reset = 1'b0;
    fifo.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("partial_writes_seen", exp_addr.size(), 0);
    check("partial_busy_after_reset", bus.busy, 1'b1);
    check("partial_done_after_reset", bus.done, 1'b0);
    set_frame1();
    run_frame("reload", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
